// File: rtl/ising_readout.sv
// Result consumer for the Ising solver: binarizes the final phases into spins on done,
// accumulates the Ising energy one upper-triangle coupling per cycle, then offers it on valid/ready.
module ising_readout #(
   parameter  int N              = 16,
   parameter  int fractionalBits = 16,
   parameter  int dataWidth      = 32,
   localparam int EW             = dataWidth + $clog2(N*N)
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic                        done,
   input  logic signed [dataWidth-1:0] finalPhases    [N],
   input  logic signed [dataWidth-1:0] couplingMatrix [N][N],
   output logic                        result_valid,
   input  logic                        result_ready,
   output logic        [N-1:0]         spins,
   output logic signed [EW-1:0]        energy,
   output logic                        busy,
   output logic                        overrun
);

   localparam int IW = $clog2(N);
   // Phase window [0.5, 1.5) in units of pi, on the low F+1 bits (phase mod 2.0)
   localparam logic [fractionalBits:0] LO = {2'b01, {(fractionalBits-1){1'b0}}};
   localparam logic [fractionalBits:0] HI = {2'b11, {(fractionalBits-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

   state_t                r_state;
   logic [IW-1:0]         r_i;
   logic [IW-1:0]         r_j;
   logic                  r_fin;
   logic signed [EW-1:0]  r_acc;

   logic [N-1:0]          w_spins;
   logic [dataWidth-1:0]  w_j;
   logic signed [EW-1:0]  w_jext;
   logic signed [EW-1:0]  w_term;

   always_comb begin
      w_spins = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_spins[k] = !((finalPhases[k][fractionalBits:0] >= LO) &&
                        (finalPhases[k][fractionalBits:0] <  HI));
      end
   end

   assign w_j    = couplingMatrix[r_i][r_j];
   assign w_jext = {{(EW-dataWidth){w_j[dataWidth-1]}}, w_j};
   assign w_term = (spins[r_i] == spins[r_j]) ? w_jext : -w_jext;

   // The extra r_fin cycle lets the last pair land in r_acc before energy is published.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= IDLE;
         r_i          <= '0;
         r_j          <= '0;
         r_fin        <= 1'b0;
         r_acc        <= '0;
         result_valid <= 1'b0;
         spins        <= '0;
         energy       <= '0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (done && (r_state != IDLE))
            overrun <= 1'b1;
         case (r_state)
            IDLE: begin
               if (done) begin
                  spins   <= w_spins;
                  r_acc   <= '0;
                  r_i     <= '0;
                  r_j     <= IW'(1);
                  r_fin   <= 1'b0;
                  busy    <= 1'b1;
                  r_state <= ACCUM;
               end
            end
            ACCUM: begin
               if (r_fin) begin
                  energy       <= -r_acc;
                  result_valid <= 1'b1;
                  r_state      <= RESULT;
               end else begin
                  r_acc <= r_acc + w_term;
                  if (r_j == IW'(N-1)) begin
                     if (r_i == IW'(N-2)) begin
                        r_fin <= 1'b1;
                     end else begin
                        r_i <= r_i + IW'(1);
                        r_j <= r_i + IW'(2);
                     end
                  end else begin
                     r_j <= r_j + IW'(1);
                  end
               end
            end
            RESULT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ising_readout.sv
// Self-checking bench for ising_readout (N=4): transaction-level reference model compared every
// cycle, plus directed scenarios with hand-computed spins, energies and latency.
module tb_ising_readout;

   localparam int N  = 4;
   localparam int F  = 16;
   localparam int DW = 32;
   localparam int EW = DW + $clog2(N*N);
   localparam int P  = N*(N-1)/2;
   localparam logic signed [DW-1:0] ONE = 32'h0001_0000;

   logic                 clk = 1'b0;
   logic                 n_rst = 1'b0;
   logic                 done = 1'b0;
   logic signed [DW-1:0] ph [N];
   logic signed [DW-1:0] J  [N][N];
   logic                 result_valid;
   logic                 result_ready = 1'b1;
   logic [N-1:0]         spins;
   logic [EW-1:0]        energy;
   logic                 busy;
   logic                 overrun;

   int n_cmp  = 0;
   int n_fail = 0;

   ising_readout #(.N(N), .fractionalBits(F), .dataWidth(DW)) dut (
      .clk(clk), .n_rst(n_rst), .done(done), .finalPhases(ph), .couplingMatrix(J),
      .result_valid(result_valid), .result_ready(result_ready), .spins(spins),
      .energy(energy), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] lit(input longint v);
      return v[EW-1:0];
   endfunction

   // Reference: phase taken mod 2.0 (units of pi); spin -1 inside [0.5, 1.5)
   function automatic logic [N-1:0] model_spins();
      logic [N-1:0] s;
      for (int i = 0; i < N; i++) begin
         real r;
         r = real'(ph[i] & 32'h0001_FFFF) / 65536.0;
         s[i] = !(r >= 0.5 && r < 1.5);
      end
      return s;
   endfunction

   function automatic longint model_energy(input logic [N-1:0] s);
      longint e = 0;
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            e -= longint'(J[i][j]) * ((s[i] == s[j]) ? 1 : -1);
      return e;
   endfunction

   logic         m_valid = 0, m_busy = 0, m_overrun = 0;
   logic [N-1:0] m_spins = '0;
   longint       m_energy = 0;
   int           m_cnt = 0;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_valid = 0; m_busy = 0; m_overrun = 0; m_spins = '0; m_energy = 0; m_cnt = 0;
      end else begin
         if (done && m_busy) m_overrun = 1;
         if (!m_busy) begin
            if (done) begin
               m_spins = model_spins();
               m_cnt   = P + 1;
               m_busy  = 1;
            end
         end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_valid  = 1;
               m_energy = model_energy(m_spins);
            end
         end else if (m_valid && result_ready) begin
            m_valid = 0;
            m_busy  = 0;
         end
      end
   end

   always @(negedge clk) begin
      check("m_valid",   result_valid, m_valid);
      check("m_busy",    busy,         m_busy);
      check("m_overrun", overrun,      m_overrun);
      check("m_spins",   spins,        m_spins);
      check("m_energy",  energy,       lit(m_energy));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   task automatic wait_valid(input string nm, output int lat);
      lat = 0;
      while (!result_valid && lat < 300) begin
         tick();
         lat++;
      end
      if (!result_valid) check({nm, "_timeout"}, 0, 1);
   endtask

   task automatic set_all(input logic signed [DW-1:0] p, input logic signed [DW-1:0] c);
      for (int i = 0; i < N; i++) begin
         ph[i] = p;
         for (int j = 0; j < N; j++) J[i][j] = c;
      end
   endtask

   task automatic setup_t2();
      set_all(0, ONE);
      ph[1] = ONE;
      ph[3] = ONE;
   endtask

   initial begin
      int lat;
      set_all(0, ONE);
      tick();
      tick();
      check("rst_valid", result_valid, 0);
      check("rst_spins", spins, 0);
      check("rst_energy", energy, 0);
      check("rst_busy", busy, 0);
      n_rst = 1'b1;
      tick();

      // Test 1
      start();
      check("t1_busy", busy, 1);
      wait_valid("t1", lat);
      check("t1_latency", lat, 7);
      check("t1_spins", spins, 4'b1111);
      check("t1_energy", energy, lit(-6 * 65536));
      tick();

      // Test 2
      setup_t2();
      start();
      wait_valid("t2", lat);
      check("t2_spins", spins, 4'b0101);
      check("t2_energy", energy, lit(2 * 65536));
      tick();
      check("t2_pulse", result_valid, 0);

      // Test 3
      set_all(0, ONE);
      ph[0] = 32'h0000_7FFF; ph[1] = 32'h0000_8000; ph[2] = 32'h0001_8000; ph[3] = 32'hFFFF_8000;
      start();
      wait_valid("t3", lat);
      check("t3_spins", spins, 4'b1101);
      tick();

      // Test 4
      set_all(0, ONE);
      result_ready = 1'b0;
      start();
      wait_valid("t4", lat);
      for (int c = 0; c < 5; c++) begin
         done = (c == 2);
         tick();
         check("t4_hold_valid", result_valid, 1);
         check("t4_hold_energy", energy, lit(-6 * 65536));
      end
      done = 1'b0;
      check("t4_overrun", overrun, 1);
      result_ready = 1'b1;
      tick();
      check("t4_valid_drop", result_valid, 0);
      check("t4_busy_drop", busy, 0);

      // Test 5
      setup_t2();
      start();
      tick(); tick(); tick();
      n_rst = 1'b0;
      #1;
      check("t5_valid", result_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_spins", spins, 0);
      check("t5_energy", energy, 0);
      check("t5_overrun", overrun, 0);
      tick();
      n_rst = 1'b1;
      tick();
      start();
      wait_valid("t5b", lat);
      check("t5b_energy", energy, lit(2 * 65536));
      check("t5b_overrun", overrun, 0);
      tick();

      // Test 6
      set_all(0, 0);
      J[0][1] = 32'hFFFF_8000;
      J[1][0] = 32'h0007_0000;
      start();
      wait_valid("t6", lat);
      check("t6_energy", energy, lit(32768));
      tick();

      // Randomized runs with stalls and stray done pulses while busy
      for (int it = 0; it < 40; it++) begin
         int guard;
         for (int i = 0; i < N; i++) begin
            ph[i] = $urandom;
            for (int j = 0; j < N; j++) J[i][j] = $urandom;
         end
         result_ready = $urandom_range(0, 1);
         start();
         guard = 0;
         while (m_busy && guard < 400) begin
            result_ready = $urandom_range(0, 1);
            done = ($urandom_range(0, 15) == 0);
            tick();
            guard++;
         end
         done = 1'b0;
         if (m_busy) check("rand_timeout", 0, 1);
         result_ready = 1'b1;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
